// File: rtl/iob_axistream_in_packer_pkg.sv
// rtl/iob_axistream_in_packer_pkg.sv - shared types and sizing helpers for the stream-in packer.
package iob_axistream_in_packer_pkg;

   localparam int WORD_W = 32;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_FILL = 1'b1
   } state_t;

   // Beats per packed word.
   function automatic int beats_per_word(input int tdata_w);
      return WORD_W / tdata_w;
   endfunction

   // FIFO entry layout is {last, strb, data}.
   function automatic int entry_w(input int tdata_w);
      return WORD_W + beats_per_word(tdata_w) + 1;
   endfunction

endpackage

// File: rtl/iob_fifo_sync.sv
// rtl/iob_fifo_sync.sv - single-clock first-word-fall-through FIFO over iob_ram_2p.
module iob_fifo_sync #(
   parameter int W          = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                clk_i,
   input  logic                cke_i,
   input  logic                rst_i,
   input  logic                w_en_i,
   input  logic [W-1:0]        w_data_i,
   input  logic                r_en_i,
   output logic [W-1:0]        r_data_o,
   output logic                empty_o,
   output logic                full_o,
   output logic [DEPTH_LOG2:0] level_o
);

   localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;

   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic                  push, pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == DEPTH);
   assign level_o = level_q;
   assign push    = w_en_i & cke_i & ~full_o & ~rst_i;
   assign pop     = r_en_i & cke_i & ~empty_o & ~rst_i;

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + (DEPTH_LOG2+1)'(1);
         2'b01:   level_d = level_q - (DEPTH_LOG2+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + (DEPTH_LOG2)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (DEPTH_LOG2)'(1);
         level_q <= level_d;
      end
   end

   iob_ram_2p #(
      .W      (W),
      .ADDR_W (DEPTH_LOG2)
   ) u_ram (
      .clk_i    (clk_i),
      .w_en_i   (push),
      .w_addr_i (wr_ptr_q),
      .w_data_i (w_data_i),
      .r_addr_i (rd_ptr_q),
      .r_data_o (r_data_o)
   );

endmodule

// File: rtl/iob_ram_2p.sv
// rtl/iob_ram_2p.sv - two-port RAM, synchronous write, asynchronous read.
module iob_ram_2p #(
   parameter int W      = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              w_en_i,
   input  logic [ADDR_W-1:0] w_addr_i,
   input  logic [W-1:0]      w_data_i,
   input  logic [ADDR_W-1:0] r_addr_i,
   output logic [W-1:0]      r_data_o
);

   logic [W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk_i) begin
      if (w_en_i) begin
         mem[w_addr_i] <= w_data_i;
      end
   end

   assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/iob_axistream_in_packer.sv
// rtl/iob_axistream_in_packer.sv - packs AXIS beats into 32-bit words queued in a FWFT FIFO.
// Optional 16-bit packet counter output enabled by IOB_AXISTREAM_IN_PKT_CNT_EN.
module iob_axistream_in_packer
   import iob_axistream_in_packer_pkg::*;
#(
   parameter int TDATA_W         = 8,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic                             clk_i,
   input  logic                             cke_i,
   input  logic                             rst_i,
   input  logic                             enable_i,
   input  logic [TDATA_W-1:0]               axis_tdata_i,
   input  logic                             axis_tvalid_i,
   output logic                             axis_tready_o,
   input  logic                             axis_tlast_i,
   output logic [WORD_W-1:0]                word_data_o,
   output logic [beats_per_word(TDATA_W)-1:0] word_strb_o,
   output logic                             word_last_o,
   output logic                             word_valid_o,
   input  logic                             word_ready_i,
   output logic [FIFO_DEPTH_LOG2:0]         level_o,
   input  logic [FIFO_DEPTH_LOG2:0]         threshold_i,
   input  logic                             interrupt_en_i,
   output logic                             interrupt_o
`ifdef IOB_AXISTREAM_IN_PKT_CNT_EN
   ,
   output logic [15:0]                      pkt_cnt_o
`endif
);

   localparam int N       = beats_per_word(TDATA_W);
   localparam int ENTRY_W = entry_w(TDATA_W);
   localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;

   state_t             state_q;
   logic [CNT_W-1:0]   beat_cnt_q;
   logic [WORD_W-1:0]  data_q, data_d, beat_ext;
   logic [N-1:0]       strb_q, strb_d;
   logic               beat_acc, last_beat, fifo_full, fifo_empty;
   logic [ENTRY_W-1:0] head;

   assign axis_tready_o = enable_i & ~fifo_full & ~rst_i;
   assign beat_acc      = axis_tvalid_i & axis_tready_o & cke_i;
   assign last_beat     = (beat_cnt_q == CNT_W'(N-1)) | axis_tlast_i;

   // In IDLE the lane registers are known empty, so merge onto zero.
   always_comb begin
      beat_ext = WORD_W'(axis_tdata_i) << (int'(beat_cnt_q) * TDATA_W);
      data_d   = ((state_q == S_IDLE) ? '0 : data_q) | beat_ext;
      strb_d   = ((state_q == S_IDLE) ? '0 : strb_q) | (N'(1) << beat_cnt_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         beat_cnt_q <= '0;
         data_q     <= '0;
         strb_q     <= '0;
      end else if (beat_acc) begin
         if (last_beat) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            data_q     <= '0;
            strb_q     <= '0;
         end else begin
            state_q    <= S_FILL;
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            data_q     <= data_d;
            strb_q     <= strb_d;
         end
      end
   end

   iob_fifo_sync #(
      .W          (ENTRY_W),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk_i    (clk_i),
      .cke_i    (cke_i),
      .rst_i    (rst_i),
      .w_en_i   (beat_acc & last_beat),
      .w_data_i ({axis_tlast_i, strb_d, data_d}),
      .r_en_i   (word_ready_i),
      .r_data_o (head),
      .empty_o  (fifo_empty),
      .full_o   (fifo_full),
      .level_o  (level_o)
   );

   // Head is masked while empty so stale RAM contents never reach the host.
   assign word_valid_o = ~fifo_empty;
   assign word_data_o  = word_valid_o ? head[WORD_W-1:0] : '0;
   assign word_strb_o  = word_valid_o ? head[WORD_W +: N] : '0;
   assign word_last_o  = word_valid_o & head[ENTRY_W-1];
   assign interrupt_o  = interrupt_en_i & (level_o != '0) & (level_o >= threshold_i);

`ifdef IOB_AXISTREAM_IN_PKT_CNT_EN
   logic [15:0] pkt_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pkt_cnt_q <= '0;
      end else if (beat_acc & axis_tlast_i) begin
         pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
   end

   assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule
